// File: rtl/cpu_checker_fsm.sv
// cpu_checker_fsm: character-serial recogniser for CPU trace records.
// Register write: ^T@P: $G <= D#    Memory write: ^T@P: *A <= D#
// format_type pulses 1 (register) or 2 (memory) for the cycle after '#'.
// Optional build macro CPU_CHECKER_ERROR_CODE_EN adds the freq input and the
// error_code output, backed by value accumulators for T, G, P and A.
`timescale 1ns/1ps
module cpu_checker_fsm #(
  parameter int TIME_DIGITS_MAX = 4,
  parameter int HEX_DIGITS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic [1:0] format_type
`ifdef CPU_CHECKER_ERROR_CODE_EN
  ,
  input  logic [15:0] freq,
  output logic [3:0]  error_code
`endif
);

  localparam int CNT_MAX = (TIME_DIGITS_MAX > HEX_DIGITS) ? TIME_DIGITS_MAX : HEX_DIGITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEC_CNT = CNT_W'(TIME_DIGITS_MAX);
  localparam logic [CNT_W-1:0] HEX_CNT = CNT_W'(HEX_DIGITS);

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON, SPC1, GRF, ADDR, SPC2, LT, SPC3, DATA, SPC4,
    DONE_REG, DONE_MEM, ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             is_mem, mem_n;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Lowercase only: 'A'-'F' is deliberately not a hex digit here.
  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Next-state, field-length counter and record-kind selection
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mem_n   = is_mem;
    if (char == CH_CARET) begin
      state_n = TIME;
      cnt_n   = '0;
      mem_n   = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        TIME: begin
          if (is_dec(char) && cnt < DEC_CNT) cnt_n = cnt + 1'b1;
          else if (char == CH_AT && cnt != '0) begin
            state_n = PC;
            cnt_n   = '0;
          end else state_n = ERR;
        end
        PC: begin
          if (is_hex(char) && cnt < HEX_CNT) cnt_n = cnt + 1'b1;
          else if (char == CH_COLON && cnt == HEX_CNT) state_n = COLON;
          else state_n = ERR;
        end
        COLON, SPC1: begin
          cnt_n = '0;
          if (char == CH_SP) state_n = SPC1;
          else if (char == CH_DOLLAR) begin
            state_n = GRF;
            mem_n   = 1'b0;
          end else if (char == CH_STAR) begin
            state_n = ADDR;
            mem_n   = 1'b1;
          end else state_n = ERR;
        end
        GRF: begin
          if (is_dec(char) && cnt < DEC_CNT) cnt_n = cnt + 1'b1;
          else if (char == CH_SP && cnt != '0) state_n = SPC2;
          else if (char == CH_LT && cnt != '0) state_n = LT;
          else state_n = ERR;
        end
        ADDR: begin
          if (is_hex(char) && cnt < HEX_CNT) cnt_n = cnt + 1'b1;
          else if (char == CH_SP && cnt == HEX_CNT) state_n = SPC2;
          else if (char == CH_LT && cnt == HEX_CNT) state_n = LT;
          else state_n = ERR;
        end
        SPC2: begin
          if (char == CH_LT) state_n = LT;
          else if (char != CH_SP) state_n = ERR;
        end
        LT: state_n = (char == CH_EQ) ? SPC3 : ERR;
        SPC3: begin
          if (is_hex(char)) begin
            state_n = DATA;
            cnt_n   = CNT_W'(1);
          end else if (char != CH_SP) state_n = ERR;
        end
        DATA: begin
          if (is_hex(char) && cnt < HEX_CNT) cnt_n = cnt + 1'b1;
          else if (char == CH_SP && cnt == HEX_CNT) state_n = SPC4;
          else if (char == CH_HASH && cnt == HEX_CNT) state_n = is_mem ? DONE_MEM : DONE_REG;
          else state_n = ERR;
        end
        SPC4: begin
          if (char == CH_HASH) state_n = is_mem ? DONE_MEM : DONE_REG;
          else if (char != CH_SP) state_n = ERR;
        end
        DONE_REG, DONE_MEM: state_n = IDLE;
        ERR: state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register with format_type registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      is_mem      <= 1'b0;
      format_type <= 2'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      is_mem      <= mem_n;
      format_type <= (state_n == DONE_REG) ? 2'd1 :
                     (state_n == DONE_MEM) ? 2'd2 : 2'd0;
    end
  end

`ifdef CPU_CHECKER_ERROR_CODE_EN
  logic [31:0] t_acc, g_acc, p_acc, a_acc;
  logic        acc_en;
  logic [3:0]  err_n;

  // A digit was consumed when a field state holds on a non-'^' character.
  assign acc_en = (char != CH_CARET) && (state_n == state) &&
                  (state == TIME || state == PC || state == GRF || state == ADDR);

  function automatic logic [3:0] calc_err(input logic mem, input logic [31:0] t,
                                          input logic [31:0] p, input logic [31:0] g,
                                          input logic [31:0] a, input logic [15:0] f);
    logic [15:0] half;
    logic [3:0]  e;
    half = f >> 1;
    e    = 4'd0;
    // A zero half-period only divides a zero time stamp.
    e[0] = (half == 16'd0) ? (t != 32'd0) : ((t % {16'd0, half}) != 32'd0);
    e[1] = (p < 32'h0000_3000) || (p > 32'h0000_4fff) || (p[1:0] != 2'b00);
    e[2] = mem && ((a > 32'h0000_2fff) || (a[1:0] != 2'b00));
    e[3] = !mem && (g > 32'd31);
    return e;
  endfunction

  assign err_n = calc_err(is_mem, t_acc, p_acc, g_acc, a_acc, freq);

  // Field value accumulators and the Moore error flags for completed records
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_acc      <= '0;
      g_acc      <= '0;
      p_acc      <= '0;
      a_acc      <= '0;
      error_code <= 4'd0;
    end else begin
      if (char == CH_CARET) begin
        t_acc <= '0;
        g_acc <= '0;
        p_acc <= '0;
        a_acc <= '0;
      end else if (acc_en) begin
        case (state)
          TIME:    t_acc <= t_acc * 32'd10 + {28'd0, char[3:0]};
          GRF:     g_acc <= g_acc * 32'd10 + {28'd0, char[3:0]};
          PC:      p_acc <= {p_acc[27:0], is_dec(char) ? char[3:0] : char[3:0] + 4'd9};
          ADDR:    a_acc <= {a_acc[27:0], is_dec(char) ? char[3:0] : char[3:0] + 4'd9};
          default: ;
        endcase
      end
      error_code <= (state_n == DONE_REG || state_n == DONE_MEM) ? err_n : 4'd0;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_checker_fsm.sv
// tb_cpu_checker_fsm: directed and random trace streams for cpu_checker_fsm,
// checked each cycle against a string-level grammar model.
`timescale 1ns/1ps
module tb_cpu_checker_fsm;

  localparam int TDM = 4;
  localparam int HXD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ch;
  logic [1:0] format_type;
`ifdef CPU_CHECKER_ERROR_CODE_EN
  logic [15:0] freq;
  logic [3:0]  error_code;
  logic [3:0]  last_err;
`endif

  cpu_checker_fsm #(.TIME_DIGITS_MAX(TDM), .HEX_DIGITS(HXD)) dut (
    .clk(clk),
    .reset(reset),
    .char(ch),
    .format_type(format_type)
`ifdef CPU_CHECKER_ERROR_CODE_EN
    ,
    .freq(freq),
    .error_code(error_code)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_reg, n_mem;
  logic [7:0] buf_q[$];
  logic [7:0] rec_q[$];
  bit         active;
  logic [1:0] exp_fmt;
  logic [3:0] exp_err;
  logic [7:0] pool[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_dec(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic bit is_hexl(input logic [7:0] c);
    return is_dec(c) || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] hexv(input logic [7:0] c);
    return is_dec(c) ? 4'(c - "0") : 4'(c - "a" + 8'd10);
  endfunction

  // Whole-record match of "^ ... #"; returns 0 (no match), 1 (register), 2 (memory).
  function automatic int parse_rec(input logic [7:0] q[$], output logic [31:0] t,
                                   output logic [31:0] p, output logic [31:0] g,
                                   output logic [31:0] a);
    int i, n, k, kind;
    t = 0; p = 0; g = 0; a = 0;
    n = q.size(); i = 1;
    k = 0;
    while (i < n && is_dec(q[i])) begin t = t * 10 + 32'(q[i] - "0"); i++; k++; end
    if (k < 1 || k > TDM) return 0;
    if (i >= n || q[i] != "@") return 0;
    i++; k = 0;
    while (i < n && is_hexl(q[i])) begin p = {p[27:0], hexv(q[i])}; i++; k++; end
    if (k != HXD) return 0;
    if (i >= n || q[i] != ":") return 0;
    i++;
    while (i < n && q[i] == " ") i++;
    if (i >= n) return 0;
    k = 0;
    if (q[i] == "$") begin
      kind = 1; i++;
      while (i < n && is_dec(q[i])) begin g = g * 10 + 32'(q[i] - "0"); i++; k++; end
      if (k < 1 || k > TDM) return 0;
    end else if (q[i] == "*") begin
      kind = 2; i++;
      while (i < n && is_hexl(q[i])) begin a = {a[27:0], hexv(q[i])}; i++; k++; end
      if (k != HXD) return 0;
    end else return 0;
    while (i < n && q[i] == " ") i++;
    if (i + 1 >= n || q[i] != "<" || q[i+1] != "=") return 0;
    i += 2;
    while (i < n && q[i] == " ") i++;
    k = 0;
    while (i < n && is_hexl(q[i])) begin i++; k++; end
    if (k != HXD) return 0;
    while (i < n && q[i] == " ") i++;
    if (i != n - 1 || q[i] != "#") return 0;
    return kind;
  endfunction

  task automatic model_step(input logic [7:0] c);
    logic [31:0] t, p, g, a;
    logic [15:0] half;
    int kind;
    exp_fmt = 2'd0;
    exp_err = 4'd0;
    if (c == "^") begin
      buf_q.delete();
      buf_q.push_back(c);
      active = 1'b1;
    end else if (active) begin
      buf_q.push_back(c);
      if (c == "#") begin
        kind = parse_rec(buf_q, t, p, g, a);
        exp_fmt = 2'(kind);
`ifdef CPU_CHECKER_ERROR_CODE_EN
        if (kind != 0) begin
          half = freq >> 1;
          exp_err[0] = (half == 0) ? (t != 0) : ((t % 32'(half)) != 0);
          exp_err[1] = (p < 32'h3000) || (p > 32'h4fff) || (p % 4 != 0);
          exp_err[2] = (kind == 2) && ((a > 32'h2fff) || (a % 4 != 0));
          exp_err[3] = (kind == 1) && (g > 31);
        end
`else
        half = 16'(t ^ p ^ g ^ a);
`endif
      end
    end
  endtask

  // Check the response to the previous character, then present the next one.
  task automatic drive(input logic [7:0] c);
    @(negedge clk);
    check_eq("format_type", 32'(format_type), 32'(exp_fmt));
    if (format_type == 2'd1) n_reg++;
    if (format_type == 2'd2) n_mem++;
`ifdef CPU_CHECKER_ERROR_CODE_EN
    check_eq("error_code", 32'(error_code), 32'(exp_err));
    if (format_type != 2'd0) last_err = error_code;
`endif
    ch = c;
    model_step(c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(s.getc(i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ch = " ";
    active = 1'b0;
    buf_q.delete();
    exp_fmt = 2'd0;
    exp_err = 4'd0;
    #1;
    check_eq("reset_fmt", 32'(format_type), 32'd0);
`ifdef CPU_CHECKER_ERROR_CODE_EN
    check_eq("reset_err", 32'(error_code), 32'd0);
`endif
    repeat (2) @(negedge clk);
    check_eq("reset_hold_fmt", 32'(format_type), 32'd0);
    reset = 1'b0;
  endtask

  task automatic push_dec(input logic [31:0] v, input int nd);
    int pw;
    for (int i = nd - 1; i >= 0; i--) begin
      pw = 1;
      for (int j = 0; j < i; j++) pw *= 10;
      rec_q.push_back(8'h30 + 8'((v / 32'(pw)) % 10));
    end
  endtask

  task automatic push_hex(input logic [31:0] v, input int nd);
    logic [3:0] nib;
    for (int i = nd - 1; i >= 0; i--) begin
      nib = (i < 8) ? v[i*4 +: 4] : 4'h0;
      if (nib < 4'd10) rec_q.push_back(8'h30 + 8'(nib));
      else rec_q.push_back((($urandom_range(0, 24) == 0) ? 8'h41 : 8'h61) + 8'(nib) - 8'd10);
    end
  endtask

  task automatic push_sp(input int n);
    for (int i = 0; i < n; i++) rec_q.push_back(" ");
  endtask

  function automatic int hex_len();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? 7 : 9;
    return HXD;
  endfunction

  task automatic build_rec();
    int nd;
    logic [31:0] v;
    rec_q.delete();
    rec_q.push_back("^");
    nd = ($urandom_range(0, 9) == 0) ? 5 * int'($urandom_range(0, 1)) : int'($urandom_range(1, TDM));
    push_dec($urandom % 10000, nd);
    rec_q.push_back("@");
    v = $urandom_range(32'h2ff0, 32'h5010);
    if ($urandom_range(0, 1) == 0) v[1:0] = 2'b00;
    push_hex(v, hex_len());
    rec_q.push_back(":");
    push_sp($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 0) begin
      rec_q.push_back("$");
      push_dec($urandom % 40, $urandom_range(1, 2));
    end else begin
      rec_q.push_back("*");
      v = $urandom_range(0, 32'h3010);
      if ($urandom_range(0, 1) == 0) v[1:0] = 2'b00;
      push_hex(v, hex_len());
    end
    push_sp($urandom_range(0, 2));
    rec_q.push_back("<");
    if ($urandom_range(0, 19) == 0) rec_q.push_back(" ");
    rec_q.push_back("=");
    push_sp($urandom_range(0, 2));
    push_hex($urandom, hex_len());
    push_sp($urandom_range(0, 2));
    rec_q.push_back("#");
  endtask

  task automatic mutate_rec();
    int pos;
    pos = $urandom_range(1, rec_q.size() - 1);
    case ($urandom_range(0, 2))
      0: rec_q[pos] = pool[$urandom_range(0, 15)];
      1: rec_q.delete(pos);
      default: rec_q.insert(pos, pool[$urandom_range(0, 15)]);
    endcase
  endtask

  string ds[15];
  int    er[15];
  int    em[15];

  initial begin
    pool = '{8'h30, 8'h39, 8'h61, 8'h66, 8'h46, 8'h41, 8'h20, 8'h23,
             8'h3C, 8'h3D, 8'h24, 8'h2A, 8'h40, 8'h3A, 8'h78, 8'h5E};
    ds = '{"^242@000030f4: $31 <=12345678#",
           "^338@00003130: *00000088 <= ffffb528#",
           "^338@00003130: *00000088 <= Ffffb528#",
           "^242@000030f4: $31 <=1232158998#",
           "^242@000030f4: $31 <=#",
           "x242@000030f4: $31 <=ab123215#",
           "^242@000030f4: $31 <=Ab123215#",
           "^338@00003130: *00000088 <= ffffb52#",
           "^338@00003130: *00000088 <= ffffB528#",
           "^338@00003130: *00000088 <= ffffb52B#",
           "^338@00003130: *00000088 <= ffffb528 #",
           "^12345@000030f4: $31 <=12345678#",
           "^1@000030f4: $1 < =12345678#",
           "^1@000030f4:$1<=12345678#^0000@00003000:   *00002ffc   <=   0000000a   #",
           "^1@00003000: $1 <=12^9@00003000: $2<=00000000#"};
    er = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    em = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};

    reset = 1'b1;
    ch = " ";
    active = 1'b0;
    exp_fmt = 2'd0;
    exp_err = 4'd0;
    n_reg = 0;
    n_mem = 0;
`ifdef CPU_CHECKER_ERROR_CODE_EN
    freq = 16'd2;
    last_err = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check_eq("reset_fmt", 32'(format_type), 32'd0);
`ifdef CPU_CHECKER_ERROR_CODE_EN
    check_eq("reset_err", 32'(error_code), 32'd0);
`endif
    reset = 1'b0;

    // Directed records: count the pulses each one produces.
    for (int d = 0; d < 15; d++) begin
      n_reg = 0;
      n_mem = 0;
      send_str(ds[d]);
      drive(" ");
      drive(" ");
      check_eq($sformatf("dir%0d_reg_pulses", d), 32'(n_reg), 32'(er[d]));
      check_eq($sformatf("dir%0d_mem_pulses", d), 32'(n_mem), 32'(em[d]));
    end

    // Reset in the middle of a record discards it.
    n_reg = 0;
    send_str("^242@0000");
    do_reset();
    send_str("30f4: $31 <=12345678#  ");
    check_eq("after_reset_tail_pulses", 32'(n_reg), 32'd0);
    send_str("^242@000030f4: $31 <=12345678#  ");
    check_eq("after_reset_fresh_pulses", 32'(n_reg), 32'd1);

`ifdef CPU_CHECKER_ERROR_CODE_EN
    freq = 16'd2;
    last_err = 4'hF;
    send_str("^242@000030f4: $31 <= 12345678#  ");
    check_eq("err_clean_record", 32'(last_err), 32'd0);
    freq = 16'd4;
    last_err = 4'hF;
    send_str("^243@00002ffe: $32 <= 00000000#  ");
    check_eq("err_bad_record", 32'(last_err), 32'hB);
`endif

    // Random records with occasional mutations, garbage and resets.
    for (int r = 0; r < 300; r++) begin
`ifdef CPU_CHECKER_ERROR_CODE_EN
      freq = 16'(2 * $urandom_range(0, 8));
`endif
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) drive(pool[$urandom_range(0, 15)]);
      build_rec();
      if ($urandom_range(0, 3) == 0) mutate_rec();
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, rec_q.size() - 1)); k++) drive(rec_q[k]);
        do_reset();
      end else begin
        foreach (rec_q[k]) drive(rec_q[k]);
      end
    end
    drive(" ");
    drive(" ");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
